// File: rtl/perceptron_seq_ctrl_if.sv
// Host-side bundle of the perceptron sequencing controller: sample handshake,
// result handshake, weight/bias configuration port and busy status.
interface perceptron_seq_ctrl_if #(
   parameter int N_IN  = 7,
   parameter int W_W   = 8,
   parameter int IDX_W = $clog2(N_IN + 1)
);
   // Handshakes: a transfer happens on a rising edge where valid && ready are
   // both high; the sender keeps valid and its payload stable until that edge.
   logic             in_valid;
   logic             in_ready;
   logic [N_IN-1:0]  in_data;
   logic             in_train;
   logic             in_label;
   logic             out_valid;
   logic             out_ready;
   logic             out_class;
   logic             cfg_we;
   logic [IDX_W-1:0] cfg_addr;
   logic [W_W-1:0]   cfg_wdata;
   logic             busy;

   modport master (
      output in_valid, in_data, in_train, in_label, out_ready,
             cfg_we, cfg_addr, cfg_wdata,
      input  in_ready, out_valid, out_class, busy
   );

   modport slave (
      input  in_valid, in_data, in_train, in_label, out_ready,
             cfg_we, cfg_addr, cfg_wdata,
      output in_ready, out_valid, out_class, busy
   );
endinterface

// File: rtl/perceptron_seq_ctrl.sv
// Bit-serial perceptron sequencer: walks one feature per cycle against the
// weight file, thresholds the sum, and optionally applies a perceptron-rule update.
module perceptron_seq_ctrl #(
   parameter int N_IN      = 7,
   parameter int W_W       = 8,
   parameter int ACC_W     = 9,
   parameter int THRESHOLD = 64,
   parameter int W_INIT    = 128,
   parameter int LR        = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   perceptron_seq_ctrl_if.slave   bus,
   output logic [2:0]             state_dbg
);
   localparam int IDX_W = $clog2(N_IN + 1);
   localparam int SUM_W = ACC_W + 1;
   localparam int INC_W = W_W + 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_IN - 1);
   localparam logic [IDX_W-1:0] BIAS_IDX = IDX_W'(N_IN);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_ACCUM  = 3'd1,
      S_DECIDE = 3'd2,
      S_OUTPUT = 3'd3,
      S_UPDATE = 3'd4
   } state_t;

   state_t           state, state_next;
   logic [IDX_W-1:0] idx;
   logic [ACC_W-1:0] acc;
   logic [W_W-1:0]   w [N_IN];
   logic [W_W-1:0]   bias;
   logic [N_IN-1:0]  lat_data;
   logic             lat_train;
   logic             lat_label;
   logic             out_valid_q;
   logic             out_class_q;

   logic             in_ready_c;
   logic             cfg_apply;
   logic             accept, accum_step, decide, out_hs, upd_step;
   logic [W_W-1:0]   w_sel;
   logic             bit_sel;
   logic [SUM_W-1:0] acc_sum;
   logic [ACC_W-1:0] acc_sat;
   logic [INC_W-1:0] w_inc;
   logic [W_W-1:0]   w_up, w_dn, w_new;

   assign in_ready_c    = (state == S_IDLE) && !bus.cfg_we;
   assign cfg_apply     = (state == S_IDLE) && bus.cfg_we;
   assign bus.in_ready  = in_ready_c;
   assign bus.out_valid = out_valid_q;
   assign bus.out_class = out_class_q;
   assign bus.busy      = (state != S_IDLE);
   assign state_dbg     = state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      accept     = 1'b0;
      accum_step = 1'b0;
      decide     = 1'b0;
      out_hs     = 1'b0;
      upd_step   = 1'b0;
      case (state)
         S_IDLE: begin
            if (bus.in_valid && in_ready_c) begin
               accept     = 1'b1;
               state_next = S_ACCUM;
            end
         end
         S_ACCUM: begin
            accum_step = 1'b1;
            if (idx == LAST_IDX) state_next = S_DECIDE;
         end
         S_DECIDE: begin
            decide     = 1'b1;
            state_next = S_OUTPUT;
         end
         S_OUTPUT: begin
            if (bus.out_ready) begin
               out_hs     = 1'b1;
               state_next = (lat_train && (out_class_q != lat_label)) ? S_UPDATE : S_IDLE;
            end
         end
         S_UPDATE: begin
            upd_step = 1'b1;
            if (idx == BIAS_IDX) state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   // idx == N_IN addresses the bias, which is always adjusted during UPDATE.
   always_comb begin
      w_sel   = '0;
      bit_sel = 1'b0;
      for (int i = 0; i < N_IN; i++) begin
         if (idx == IDX_W'(i)) begin
            w_sel   = w[i];
            bit_sel = lat_data[i];
         end
      end
      if (idx == BIAS_IDX) begin
         w_sel   = bias;
         bit_sel = 1'b1;
      end
   end

   always_comb begin
      acc_sum = {1'b0, acc} + SUM_W'(w_sel);
      acc_sat = acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];
      w_inc   = {1'b0, w_sel} + INC_W'(LR);
      w_up    = w_inc[W_W] ? '1 : w_inc[W_W-1:0];
      w_dn    = (w_sel >= W_W'(LR)) ? (w_sel - W_W'(LR)) : '0;
      w_new   = lat_label ? w_up : w_dn;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_IN; i++) w[i] <= W_W'(W_INIT);
         bias        <= '0;
         acc         <= '0;
         idx         <= '0;
         lat_data    <= '0;
         lat_train   <= 1'b0;
         lat_label   <= 1'b0;
         out_valid_q <= 1'b0;
         out_class_q <= 1'b0;
      end else begin
         if (accept) begin
            lat_data  <= bus.in_data;
            lat_train <= bus.in_train;
            lat_label <= bus.in_label;
            acc       <= ACC_W'(bias);
            idx       <= '0;
         end
         if (accum_step) begin
            if (bit_sel) acc <= acc_sat;
            idx <= idx + IDX_W'(1);
         end
         if (decide) begin
            out_class_q <= (acc >= ACC_W'(THRESHOLD));
            out_valid_q <= 1'b1;
         end
         if (out_hs) begin
            out_valid_q <= 1'b0;
            idx         <= '0;
         end
         if (upd_step) begin
            for (int i = 0; i < N_IN; i++) begin
               if (idx == IDX_W'(i) && bit_sel) w[i] <= w_new;
            end
            if (idx == BIAS_IDX) bias <= w_new;
            idx <= (idx == BIAS_IDX) ? '0 : idx + IDX_W'(1);
         end
         // Config writes only land in IDLE, where no sample is being accepted.
         if (cfg_apply) begin
            for (int i = 0; i < N_IN; i++) begin
               if (bus.cfg_addr == IDX_W'(i)) w[i] <= bus.cfg_wdata;
            end
            if (bus.cfg_addr == BIAS_IDX) bias <= bus.cfg_wdata;
         end
      end
   end
endmodule

// File: tb/tb_perceptron_seq_ctrl.sv
// Directed bench for perceptron_seq_ctrl: classification, saturation, config,
// training steps, ignored writes, mid-operation reset and back-to-back flow.
module tb_perceptron_seq_ctrl;
   localparam int N_IN  = 7;
   localparam int W_W   = 8;
   localparam int IDX_W = 3;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [2:0] state_dbg;
   int         n_checks = 0;
   int         n_fail = 0;
   logic [0:0] exp_q[$];

   always #5 clk = ~clk;

   perceptron_seq_ctrl_if #(.N_IN(N_IN), .W_W(W_W), .IDX_W(IDX_W)) bus ();

   perceptron_seq_ctrl #(
      .N_IN(N_IN), .W_W(W_W), .ACC_W(9), .THRESHOLD(64), .W_INIT(128), .LR(16)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus), .state_dbg(state_dbg)
   );

   // ---------------- driver tasks ----------------
   task automatic drive_idle();
      bus.in_valid = 0; bus.in_data = '0; bus.in_train = 0; bus.in_label = 0;
      bus.out_ready = 0; bus.cfg_we = 0; bus.cfg_addr = '0; bus.cfg_wdata = '0;
   endtask

   task automatic do_reset();
      drive_idle();
      rst_n = 0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1;
   endtask

   task automatic cfg_write(input logic [IDX_W-1:0] addr, input logic [W_W-1:0] data);
      bus.cfg_we = 1; bus.cfg_addr = addr; bus.cfg_wdata = data;
      @(posedge clk); #1;
      bus.cfg_we = 0;
   endtask

   task automatic start(input logic [N_IN-1:0] data, input logic train, input logic label,
                        output bit ok);
      ok = 0;
      for (int i = 0; i < 40 && !ok; i++) begin
         if (bus.in_ready) ok = 1;
         else begin @(posedge clk); #1; end
      end
      if (ok) begin
         bus.in_valid = 1; bus.in_data = data; bus.in_train = train; bus.in_label = label;
         @(posedge clk); #1;
         bus.in_valid = 0;
      end
   endtask

   task automatic wait_result(output int lat);
      lat = -1;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk); #1;
         if (bus.out_valid) begin lat = i; break; end
      end
   endtask

   task automatic handshake(output logic busy_after);
      bus.out_ready = 1;
      @(posedge clk); #1;
      bus.out_ready = 0;
      busy_after = bus.busy;
   endtask

   task automatic wait_idle(output int cyc);
      cyc = -1;
      if (!bus.busy) cyc = 0;
      else begin
         for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (!bus.busy) begin cyc = i; break; end
         end
      end
   endtask

   task automatic classify(input logic [N_IN-1:0] data, input logic train, input logic label,
                           output logic cls, output int lat, output logic busy_after,
                           output int upd_cyc);
      bit ok;
      cls = 1'bx; lat = -1; busy_after = 1'bx; upd_cyc = -1;
      start(data, train, label, ok);
      if (ok) wait_result(lat);
      if (lat > 0) begin
         cls = bus.out_class;
         handshake(busy_after);
         wait_idle(upd_cyc);
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      do_reset();
      n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
      n_checks++; if (bus.out_class !== 1'b0) begin n_fail++; $display("FAIL reset_out_class: got %b want 0", bus.out_class); end
      n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
      n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
      n_checks++; if (state_dbg !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", state_dbg); end
   endtask

   task automatic test_zero_vector();
      logic cls, ba; int lat, uc;
      classify(7'b0000000, 0, 0, cls, lat, ba, uc);
      n_checks++; if (lat !== 8) begin n_fail++; $display("FAIL zero_latency: got %0d want 8", lat); end
      n_checks++; if (cls !== 1'b0) begin n_fail++; $display("FAIL zero_class: got %b want 0", cls); end
   endtask

   task automatic test_cfg_weights();
      logic cls, ba; int lat, uc;
      classify(7'b0000001, 0, 0, cls, lat, ba, uc);
      n_checks++; if (cls !== 1'b1) begin n_fail++; $display("FAIL cfg_w0_default: got %b want 1", cls); end
      cfg_write(3'd0, 8'd32);
      classify(7'b0000001, 0, 0, cls, lat, ba, uc);
      n_checks++; if (cls !== 1'b0) begin n_fail++; $display("FAIL cfg_w0_32: got %b want 0", cls); end
      cfg_write(3'd7, 8'd40);
      classify(7'b0000001, 0, 0, cls, lat, ba, uc);
      n_checks++; if (cls !== 1'b1) begin n_fail++; $display("FAIL cfg_bias_40: got %b want 1", cls); end
      classify(7'b0000000, 0, 0, cls, lat, ba, uc);
      n_checks++; if (cls !== 1'b0) begin n_fail++; $display("FAIL cfg_bias_only: got %b want 0", cls); end
   endtask

   task automatic test_saturation();
      logic cls, ba; int lat, uc; bit ok;
      do_reset();
      classify(7'b1111111, 0, 0, cls, lat, ba, uc);
      n_checks++; if (cls !== 1'b1) begin n_fail++; $display("FAIL sat_all_ones: got %b want 1", cls); end
      n_checks++; if (lat !== 8) begin n_fail++; $display("FAIL sat_latency: got %0d want 8", lat); end
      // 4*128 = 512 would wrap to 0 without saturation
      classify(7'b0001111, 0, 0, cls, lat, ba, uc);
      n_checks++; if (cls !== 1'b1) begin n_fail++; $display("FAIL sat_wrap512: got %b want 1", cls); end
      start(7'b1111111, 0, 0, ok);
      wait_result(lat);
      n_checks++; if (lat !== 8) begin n_fail++; $display("FAIL hold_latency: got %0d want 8", lat); end
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL hold_valid[%0d]: got %b want 1", c, bus.out_valid); end
         n_checks++; if (bus.out_class !== 1'b1) begin n_fail++; $display("FAIL hold_class[%0d]: got %b want 1", c, bus.out_class); end
         n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL hold_in_ready[%0d]: got %b want 0", c, bus.in_ready); end
      end
      handshake(ba);
      n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL hold_release: got %b want 0", bus.out_valid); end
      n_checks++; if (bus.out_class !== 1'b1) begin n_fail++; $display("FAIL hold_class_kept: got %b want 1", bus.out_class); end
      wait_idle(uc);
   endtask

   task automatic test_training_down();
      logic cls, ba; int lat, uc;
      logic want_cls; int want_uc;
      do_reset();
      for (int p = 1; p <= 6; p++) begin
         classify(7'b0000001, 1, 0, cls, lat, ba, uc);
         want_cls = (p <= 5);
         want_uc  = (p <= 5) ? 8 : 0;
         n_checks++; if (cls !== want_cls) begin n_fail++; $display("FAIL train_dn_class[%0d]: got %b want %b", p, cls, want_cls); end
         n_checks++; if (uc !== want_uc) begin n_fail++; $display("FAIL train_dn_update_cycles[%0d]: got %0d want %0d", p, uc, want_uc); end
      end
      classify(7'b0000001, 0, 0, cls, lat, ba, uc);
      n_checks++; if (cls !== 1'b0) begin n_fail++; $display("FAIL train_dn_w0_48: got %b want 0", cls); end
      // bias floor: 0 + 16 < 64, a wrapped bias would push this to class 1
      cfg_write(3'd0, 8'd16);
      classify(7'b0000001, 0, 0, cls, lat, ba, uc);
      n_checks++; if (cls !== 1'b0) begin n_fail++; $display("FAIL train_dn_bias_floor: got %b want 0", cls); end
   endtask

   task automatic test_training_up();
      logic cls, ba; int lat, uc;
      logic want_cls [3] = '{1'b0, 1'b0, 1'b1};
      int   want_uc  [3] = '{8, 8, 0};
      do_reset();
      cfg_write(3'd0, 8'd0);
      // acc = bias + w0: 0 -> 32 -> 64, each miss adds 16 to both
      for (int p = 0; p < 3; p++) begin
         classify(7'b0000001, 1, 1, cls, lat, ba, uc);
         n_checks++; if (cls !== want_cls[p]) begin n_fail++; $display("FAIL train_up_class[%0d]: got %b want %b", p, cls, want_cls[p]); end
         n_checks++; if (uc !== want_uc[p]) begin n_fail++; $display("FAIL train_up_update_cycles[%0d]: got %0d want %0d", p, uc, want_uc[p]); end
      end
   endtask

   task automatic test_cfg_ignored();
      logic cls, ba; int lat, uc; bit ok;
      do_reset();
      start(7'b0000001, 0, 0, ok);
      repeat (2) @(posedge clk);
      #1 bus.cfg_we = 1; bus.cfg_addr = 3'd0; bus.cfg_wdata = 8'd0;
      @(posedge clk); #1 bus.cfg_we = 0;
      wait_result(lat);
      handshake(ba);
      wait_idle(uc);
      classify(7'b0000001, 0, 0, cls, lat, ba, uc);
      n_checks++; if (cls !== 1'b1) begin n_fail++; $display("FAIL cfg_in_accum: got %b want 1", cls); end
      start(7'b0000001, 1, 0, ok);
      wait_result(lat);
      handshake(ba);
      n_checks++; if (ba !== 1'b1) begin n_fail++; $display("FAIL cfg_upd_entered: got %b want 1", ba); end
      repeat (2) @(posedge clk);
      #1 bus.cfg_we = 1; bus.cfg_addr = 3'd0; bus.cfg_wdata = 8'd0;
      @(posedge clk); #1 bus.cfg_we = 0;
      wait_idle(uc);
      classify(7'b0000001, 0, 0, cls, lat, ba, uc);
      n_checks++; if (cls !== 1'b1) begin n_fail++; $display("FAIL cfg_in_update: got %b want 1", cls); end
      // write and sample offered together: write wins, sample waits a cycle
      bus.cfg_we = 1; bus.cfg_addr = 3'd0; bus.cfg_wdata = 8'd32;
      bus.in_valid = 1; bus.in_data = 7'b0000001; bus.in_train = 0; bus.in_label = 0;
      #1;
      n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL collide_in_ready: got %b want 0", bus.in_ready); end
      @(posedge clk); #1;
      n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL collide_not_accepted: got %b want 0", bus.busy); end
      bus.cfg_we = 0;
      #1;
      n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL collide_ready_after: got %b want 1", bus.in_ready); end
      @(posedge clk); #1;
      bus.in_valid = 0;
      n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL collide_accepted: got %b want 1", bus.busy); end
      wait_result(lat);
      n_checks++; if (lat !== 8) begin n_fail++; $display("FAIL collide_latency: got %0d want 8", lat); end
      n_checks++; if (bus.out_class !== 1'b0) begin n_fail++; $display("FAIL collide_class: got %b want 0", bus.out_class); end
      handshake(ba);
      wait_idle(uc);
   endtask

   task automatic test_reset_mid();
      logic cls, ba; int lat, uc; bit ok; int n_ones;
      do_reset();
      cfg_write(3'd0, 8'd32);
      start(7'b0000001, 0, 0, ok);
      repeat (3) @(posedge clk);
      #1 rst_n = 0;
      #1;
      n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_accum_busy: got %b want 0", bus.busy); end
      n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_accum_valid: got %b want 0", bus.out_valid); end
      n_checks++; if (state_dbg !== 3'd0) begin n_fail++; $display("FAIL rst_accum_state: got %0d want 0", state_dbg); end
      @(posedge clk); #1 rst_n = 1;
      classify(7'b0000001, 0, 0, cls, lat, ba, uc);
      n_checks++; if (cls !== 1'b1) begin n_fail++; $display("FAIL rst_accum_w0_restored: got %b want 1", cls); end
      n_checks++; if (lat !== 8) begin n_fail++; $display("FAIL rst_accum_latency: got %0d want 8", lat); end
      start(7'b0000001, 1, 0, ok);
      wait_result(lat);
      handshake(ba);
      repeat (2) @(posedge clk);
      #1 rst_n = 0;
      #1;
      n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_update_busy: got %b want 0", bus.busy); end
      @(posedge clk); #1 rst_n = 1;
      // w0 back at 128 gives exactly five class-1 passes before dropping
      n_ones = 0;
      for (int p = 0; p < 8; p++) begin
         classify(7'b0000001, 1, 0, cls, lat, ba, uc);
         if (cls === 1'b1) n_ones++;
         else break;
      end
      n_checks++; if (n_ones !== 5) begin n_fail++; $display("FAIL rst_update_w0_restored: got %0d passes want 5", n_ones); end
   endtask

   task automatic test_back_to_back();
      int n_hi, first_hi, second_hi, uc;
      logic [0:0] e;
      do_reset();
      repeat (3) exp_q.push_back(1'b1);
      n_hi = 0; first_hi = -1; second_hi = -1;
      bus.out_ready = 1;
      bus.in_valid = 1; bus.in_data = 7'b0000001; bus.in_train = 0; bus.in_label = 0;
      for (int n = 1; n <= 30; n++) begin
         @(posedge clk); #1;
         if (bus.out_valid) begin
            n_hi++;
            if (n_hi == 1) first_hi = n;
            if (n_hi == 2) second_hi = n;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
            n_checks++; if (bus.out_class !== e[0]) begin n_fail++; $display("FAIL b2b_class[%0d]: got %b want %b", n_hi, bus.out_class, e); end
         end
      end
      bus.in_valid = 0;
      bus.out_ready = 0;
      n_checks++; if (n_hi !== 3) begin n_fail++; $display("FAIL b2b_count: got %0d want 3", n_hi); end
      n_checks++; if (first_hi !== 9) begin n_fail++; $display("FAIL b2b_first: got %0d want 9", first_hi); end
      n_checks++; if (second_hi !== 19) begin n_fail++; $display("FAIL b2b_period: got %0d want 19", second_hi); end
      exp_q.delete();
      wait_idle(uc);
   endtask

   initial begin
      drive_idle();
      test_reset();
      test_zero_vector();
      test_cfg_weights();
      test_saturation();
      test_training_down();
      test_training_up();
      test_cfg_ignored();
      test_reset_mid();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/perceptron_seq_ctrl.md
Name: perceptron_seq_ctrl

Overview:
Sequencing controller for a bit-serial perceptron classifier. Accepts one N_IN-bit feature vector per transaction over a valid/ready handshake. Walks the inputs one per cycle against an internal weight file, thresholds the result and returns a class over a second valid/ready handshake. Owns weight/bias configuration and an optional on-line perceptron-rule training pass, so the host never drives the datapath directly.

Parameters:
N_IN, 7, number of input features/weights (index width IDX_W = clog2(N_IN+1))
W_W, 8, unsigned weight/bias width, Q0.W_W fraction (128 = 0.5)
ACC_W, 9, accumulator width; saturates at 2^ACC_W-1
THRESHOLD, 64, class = 1 when accumulated sum >= THRESHOLD
W_INIT, 128, reset value of every weight
LR, 16, training step applied to each weight/bias on a misclassification

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  feature vector offered
in_ready  out  1  controller can accept a vector
in_data  in  N_IN  feature bits; bit i gates weight i
in_train  in  1  sample is a training sample
in_label  in  1  expected class for training samples
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
out_class  out  1  classification result
cfg_we  in  1  weight/bias write strobe
cfg_addr  in  IDX_W  0..N_IN-1 selects a weight; N_IN selects bias; other values ignored
cfg_wdata  in  W_W  write data
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async, rst_n=0): state IDLE, all weights = W_INIT, bias = 0, acc = 0, idx = 0, out_valid = 0, out_class = 0. Any in-flight sample or update is discarded.
- in_ready = (state==IDLE) && !cfg_we. A config write has priority over a sample in the same cycle.
- cfg write takes effect on any edge with cfg_we && state==IDLE. It is silently dropped in any other state.
- States: IDLE -> ACCUM -> DECIDE -> OUTPUT -> (UPDATE ->) IDLE.
- IDLE: on in_valid && in_ready, latch in_data/in_train/in_label, load acc = bias, idx = 0, go to ACCUM.
- ACCUM: exactly N_IN cycles, one per idx = 0..N_IN-1. If the latched bit[idx] is set, acc = min(acc + w[idx], 2^ACC_W-1); otherwise acc is unchanged. After idx = N_IN-1, go to DECIDE.
- DECIDE: one cycle; out_class <= (acc >= THRESHOLD); out_valid <= 1; go to OUTPUT.
- Latency: out_valid rises N_IN+1 clock edges after the accepting edge (8 cycles at defaults).
- OUTPUT: out_valid and out_class held stable until out_ready. On the handshake edge out_valid <= 0. Next state is UPDATE if the latched train bit is set and out_class != label; otherwise IDLE.
- out_class keeps its last value after the handshake; it is only meaningful while out_valid is high.
- UPDATE: N_IN+1 cycles, idx = 0..N_IN.
  - For idx < N_IN with bit[idx] set: if label=1, w[idx] = min(w+LR, 2^W_W-1); if label=0, w[idx] = max(w-LR, 0).
  - idx = N_IN adjusts bias by the same rule.
  - Then go to IDLE.
- Correct training samples skip UPDATE entirely.
- All arithmetic is unsigned and saturating; no wrap-around is permitted anywhere.
- Back-to-back operation: with out_ready tied high, the next vector is accepted on the edge after return to IDLE.

Test Plan:
- Reset defaults, in_data=7'b0000000 -> out_valid exactly 8 cycles after accept, out_class=0 (acc=0).
- in_data=7'b0000001 -> acc=128 >= 64, out_class=1. Then cfg write w0=32 and resend -> out_class=0. Then cfg write bias (addr 7)=40 and resend -> acc=72, out_class=1.
- in_data=7'b1111111 with reset weights -> acc saturates at 511 (not 896 mod 512), out_class=1. Hold out_ready=0 for 5 cycles -> out_valid/out_class stable, in_ready=0 throughout.
- Training: in_data=7'b0000001, in_train=1, label=0, repeated.
  - Passes 1-5 return class 1 while w0 steps 128->112->96->80->64->48.
  - Pass 6 returns class 0 with no UPDATE (busy drops immediately after the handshake).
  - Bias stays 0 (floor saturation).
- cfg_we asserted during ACCUM and during UPDATE -> write ignored (read back via a classification). cfg_we and in_valid together in IDLE -> write applied, sample accepted the following cycle.
- rst_n pulsed low mid-ACCUM and mid-UPDATE -> immediate IDLE, out_valid=0, weights back to 128. Next sample behaves as after power-up.
